parity_frame_rx: RTL and testbench

//   Serial frame receiver that sits directly upstream of the 3-bit parity stage.

---
 rtl/parity_frame_rx.sv | 116 +++++++++++
 tb/tb_parity_frame_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Optional saturating error counter output err_cnt enabled by `define PARITY_RX_ERR_CNT_EN.
module parity_frame_rx #(
   parameter int DATA_W     = 3,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_valid,
   input  logic              ser_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              par_err,
   output logic              frame_err,
   output logic              busy
`ifdef PARITY_RX_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_rx;
   logic              start_en, shift_en, par_en, stop_en;
   logic              exp_par, good_stop, err_evt;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      start_en  = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      if (ser_valid) begin
         unique case (state)
            IDLE: if (!ser_in) begin
               start_en  = 1'b1;
               state_nxt = DATA;
            end
            DATA: begin
               shift_en = 1'b1;
               if (cnt == LAST_BIT) state_nxt = PAR;
            end
            PAR: begin
               par_en    = 1'b1;
               state_nxt = STOP;
            end
            STOP: begin
               stop_en   = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign exp_par   = (^shreg) ^ ODD_PARITY;
   assign good_stop = stop_en & ser_in;
   assign err_evt   = stop_en & (~ser_in | (par_rx != exp_par));

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         shreg      <= '0;
         par_rx     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy       <= (state_nxt != IDLE);
         data_valid <= good_stop;
         par_err    <= good_stop & (par_rx != exp_par);
         frame_err  <= stop_en & ~ser_in;
         if (start_en) cnt <= '0;
         if (shift_en) begin
            for (int i = 0; i < DATA_W; i++)
               if (cnt == CNT_W'(i)) shreg[i] <= ser_in;
            cnt <= cnt + 1'b1;
         end
         if (par_en)    par_rx   <= ser_in;
         if (good_stop) data_out <= shreg;
      end
   end

`ifdef PARITY_RX_ERR_CNT_EN
   // Counts the same edge that raises par_err/frame_err, saturating at 8'hFF.
   always_ff @(posedge clk) begin
      if (rst)                             err_cnt <= 8'h00;
      else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
   end
`else
   logic unused_err_evt;
   assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised scoreboard bench for parity_frame_rx: even- and odd-parity instances share one line.
// Covers err_cnt too when PARITY_RX_ERR_CNT_EN is defined.
module tb_parity_frame_rx;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst, ser_valid, ser_in;
   logic [W-1:0] d0, d1;
   logic dv0, pe0, fe0, busy0, dv1, pe1, fe1, busy1;
`ifdef PARITY_RX_ERR_CNT_EN
   logic [7:0] ec0, ec1;
`endif

   parity_frame_rx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
      .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_in(ser_in),
      .data_out(d0), .data_valid(dv0), .par_err(pe0), .frame_err(fe0), .busy(busy0)
`ifdef PARITY_RX_ERR_CNT_EN
      , .err_cnt(ec0)
`endif
   );

   parity_frame_rx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
      .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_in(ser_in),
      .data_out(d1), .data_valid(dv1), .par_err(pe1), .frame_err(fe1), .busy(busy1)
`ifdef PARITY_RX_ERR_CNT_EN
      , .err_cnt(ec1)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit           fe;
      bit           pe;
      logic [W-1:0] data;
      int           due;
   } exp_t;

   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int n_cmp = 0, n_err = 0;
   logic [W-1:0] last_good;
   int errs0, errs1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: pop one expectation for each pulse either instance presents.
   always @(negedge clk) begin
      if (dv0 || fe0) begin
         if (q0.size() == 0) check("even_unexpected_pulse", {dv0, fe0}, 2'b00);
         else begin
            e0 = q0.pop_front();
            check("even_latency", cyc, e0.due);
            check("even_frame_err", fe0, e0.fe);
            check("even_data_valid", dv0, !e0.fe);
            check("even_par_err", pe0, e0.pe);
            check("even_data_out", d0, e0.data);
         end
      end
      if (dv1 || fe1) begin
         if (q1.size() == 0) check("odd_unexpected_pulse", {dv1, fe1}, 2'b00);
         else begin
            e1 = q1.pop_front();
            check("odd_latency", cyc, e1.due);
            check("odd_frame_err", fe1, e1.fe);
            check("odd_data_valid", dv1, !e1.fe);
            check("odd_par_err", pe1, e1.pe);
            check("odd_data_out", d1, e1.data);
         end
      end
   end

   task automatic step(input bit v, input bit b);
      ser_valid = v;
      ser_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic line_bit(input bit b, input int fixed_gap, input int rand_gap);
      int g;
      g = fixed_gap + ((rand_gap > 0) ? int'($urandom_range(0, rand_gap)) : 0);
      repeat (g) step(1'b0, 1'($urandom));
      step(1'b1, b);
   endtask

   // Reference: a good frame is flagged when data ones plus parity bit has the wrong parity.
   task automatic send_frame(input logic [W-1:0] data, input bit par, input bit stop,
                             input int fixed_gap, input int rand_gap);
      int  ones;
      bit  bad_even, bad_odd;
      line_bit(1'b0, fixed_gap, rand_gap);
      check("busy_after_start", busy0, 1'b1);
      for (int i = 0; i < W; i++) line_bit(data[i], fixed_gap, rand_gap);
      line_bit(par, fixed_gap, rand_gap);
      line_bit(stop, fixed_gap, rand_gap);
      ones     = $countones(data) + int'(par);
      bad_even = (ones % 2) != 0;
      bad_odd  = (ones % 2) == 0;
      if (stop) begin
         last_good = data;
         q0.push_back('{fe: 1'b0, pe: bad_even, data: data, due: cyc});
         q1.push_back('{fe: 1'b0, pe: bad_odd, data: data, due: cyc});
         errs0 += int'(bad_even);
         errs1 += int'(bad_odd);
      end else begin
         q0.push_back('{fe: 1'b1, pe: 1'b0, data: last_good, due: cyc});
         q1.push_back('{fe: 1'b1, pe: 1'b0, data: last_good, due: cyc});
         errs0++;
         errs1++;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      ser_valid = 1'b0;
      ser_in    = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      last_good = '0;
      errs0     = 0;
      errs1     = 0;
   endtask

   // Start bit plus nbits data bits, then reset: the frame must vanish silently.
   task automatic abort_frame(input int nbits);
      line_bit(1'b0, 0, 0);
      for (int i = 0; i < nbits; i++) line_bit(1'($urandom), 0, 1);
      do_reset();
      check("busy_after_abort", busy0, 1'b0);
      check("data_after_abort", d0, '0);
   endtask

   function automatic int sat(input int n);
      return (n > 255) ? 255 : n;
   endfunction

   initial begin
      rst       = 1'b1;
      ser_valid = 1'b0;
      ser_in    = 1'b1;
      last_good = '0;
      errs0     = 0;
      errs1     = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_data_out", d0, '0);
      check("reset_flags", {dv0, pe0, fe0, busy0}, 4'b0000);
      check("reset_flags_odd", {dv1, pe1, fe1, busy1}, 4'b0000);
      step(1'b1, 1'b1);
      check("idle_ones_ignored", busy0, 1'b0);

      // Directed frames.
      send_frame(3'b101, 1'b0, 1'b1, 0, 0);
      send_frame(3'b101, 1'b1, 1'b1, 0, 0);
      send_frame(3'b110, 1'b0, 1'b0, 0, 0);
      check("data_held_after_frame_err", d0, 3'b101);
      step(1'b0, 1'b0);
      abort_frame(2);
      send_frame(3'b011, 1'b0, 1'b1, 0, 0);
      send_frame(3'b111, 1'b1, 1'b1, 2, 0);
      send_frame(3'b010, 1'b1, 1'b1, 0, 0);
      send_frame(3'b001, 1'b1, 1'b1, 0, 0);
      check("busy_after_stop", busy0, 1'b0);

      // Randomised traffic with gaps, idle ones, framing errors and aborts.
      for (int f = 0; f < 200; f++) begin
         repeat ($urandom_range(0, 2)) step(1'b1, 1'b1);
         if ($urandom_range(0, 19) == 0) abort_frame(int'($urandom_range(0, W)));
         else send_frame(W'($urandom), 1'($urandom), $urandom_range(0, 4) != 0, 0,
                         ($urandom_range(0, 1) == 0) ? 0 : 2);
      end
      repeat (3) step(1'b0, 1'b0);
      check("even_queue_drained", q0.size(), 0);
      check("odd_queue_drained", q1.size(), 0);
      check("data_matches_last_good", d0, last_good);

`ifdef PARITY_RX_ERR_CNT_EN
      check("err_cnt_even", ec0, sat(errs0));
      check("err_cnt_odd", ec1, sat(errs1));
      do_reset();
      for (int f = 0; f < 300; f++) begin
         logic [W-1:0] d;
         d = W'($urandom);
         send_frame(d, ~(^d), 1'b1, 0, 0);
      end
      step(1'b0, 1'b0);
      check("err_cnt_saturated", ec0, sat(errs0));
      check("err_cnt_ff", ec0, 8'hFF);
      do_reset();
      check("err_cnt_reset", ec0, 8'h00);
`endif

      check("even_queue_final", q0.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
